// File: rtl/dcache_wr_buffer.sv
// Write buffer between the dcache and the cache-to-AXI bridge: a small FIFO of
// pending writes with a line-granular hazard check for outstanding read misses.
module dcache_wr_buffer #(
  parameter int DEPTH = 2  // 2 or 4; pointers wrap naturally at a power of two
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         data_wr_req,
  output logic [2:0]   data_wr_type,
  output logic [31:0]  data_wr_addr,
  output logic [3:0]   data_wr_wstrb,
  output logic [127:0] data_wr_data,
  input  logic         data_wr_rdy,
  input  logic [31:0]  rd_chk_addr,
  output logic         rd_chk_hit,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

  logic [2:0]   type_q  [DEPTH];
  logic [31:0]  addr_q  [DEPTH];
  logic [3:0]   wstrb_q [DEPTH];
  logic [127:0] data_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] chk_idx;
  logic             push;
  logic             pop;

  assign wr_rdy      = (count < DEPTH_C) && !reset;
  assign data_wr_req = (count != '0);
  assign empty       = (count == '0);
  assign push        = wr_req && wr_rdy;
  assign pop         = data_wr_req && data_wr_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible through occupied slots.
  always_ff @(posedge clk) begin
    if (push) begin
      type_q[wr_ptr]  <= wr_type;
      addr_q[wr_ptr]  <= wr_addr;
      wstrb_q[wr_ptr] <= wr_wstrb;
      data_q[wr_ptr]  <= wr_data;
    end
  end

  assign data_wr_type  = data_wr_req ? type_q[rd_ptr]  : '0;
  assign data_wr_addr  = data_wr_req ? addr_q[rd_ptr]  : '0;
  assign data_wr_wstrb = data_wr_req ? wstrb_q[rd_ptr] : '0;
  assign data_wr_data  = data_wr_req ? data_q[rd_ptr]  : '0;

  // Walk occupied slots from the head; an entry being pushed is not yet stored.
  always_comb begin
    rd_chk_hit = 1'b0;
    chk_idx    = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      chk_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) &&
          (((addr_q[chk_idx] ^ rd_chk_addr) & LINE_MASK) == 32'h0))
        rd_chk_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Self-checking bench for dcache_wr_buffer against a queue-based reference model.
module tb_dcache_wr_buffer;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [127:0] d;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = '0;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;
  logic         data_wr_req;
  logic [2:0]   data_wr_type;
  logic [31:0]  data_wr_addr;
  logic [3:0]   data_wr_wstrb;
  logic [127:0] data_wr_data;
  logic         data_wr_rdy = 1'b0;
  logic [31:0]  rd_chk_addr = '0;
  logic         rd_chk_hit;
  logic         empty;

  int errors = 0;
  int checks = 0;
  ent_t mq[$];

  logic [167:0] dut_head;
  assign dut_head = {data_wr_req, data_wr_type, data_wr_addr, data_wr_wstrb, data_wr_data};

  dcache_wr_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .data_wr_req(data_wr_req), .data_wr_type(data_wr_type),
    .data_wr_addr(data_wr_addr), .data_wr_wstrb(data_wr_wstrb),
    .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
    .rd_chk_addr(rd_chk_addr), .rd_chk_hit(rd_chk_hit), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: expected head presentation and hazard from the queue contents.
  function automatic logic [167:0] exp_head();
    if (mq.size() == 0) return '0;
    return {1'b1, mq[0]};
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
    foreach (mq[i]) if (mq[i].a[31:4] == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t rand_ent(input logic [2:0] t, input logic [31:0] a);
    ent_t e;
    e.t = t;
    e.a = a;
    e.s = 4'($urandom);
    e.d = {$urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  task automatic drive(input logic req, input ent_t e);
    wr_req   = req;
    wr_type  = e.t;
    wr_addr  = e.a;
    wr_wstrb = e.s;
    wr_data  = e.d;
  endtask

  // Advance one clock edge, updating the model with the accept/pop rules.
  task automatic tick();
    bit acc, pp;
    ent_t e;
    acc = wr_req && (mq.size() < DEPTH);
    pp  = (mq.size() != 0) && data_wr_rdy;
    e   = {wr_type, wr_addr, wr_wstrb, wr_data};
    @(posedge clk);
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL rst_wr_rdy: got %b want 0", wr_rdy); end
    checks++; if (dut_head !== 168'h0) begin errors++; $display("FAIL rst_head: got %h want 0", dut_head); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
    checks++; if (rd_chk_hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b want 0", rd_chk_hit); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_wr_rdy: got %b want 1", wr_rdy); end
  endtask

  task automatic test_single_write();
    ent_t e;
    e.t = 3'b010; e.a = 32'h1FC0_0010; e.s = 4'b0011; e.d = 128'hDEAD_BEEF;
    data_wr_rdy = 1'b1;
    drive(1'b1, e);
    #1;
    checks++; if (data_wr_req !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", data_wr_req); end
    tick();
    drive(1'b0, '0);
    #1;
    checks++;
    if (dut_head !== {1'b1, 3'b010, 32'h1FC0_0010, 4'b0011, 128'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_head: got %h want %h", dut_head, {1'b1, 3'b010, 32'h1FC0_0010, 4'b0011, 128'hDEAD_BEEF});
    end
    tick();
    #1;
    checks++; if (empty !== 1'b1 || data_wr_req !== 1'b0) begin errors++; $display("FAIL single_drained: got empty=%b req=%b want 1/0", empty, data_wr_req); end
  endtask

  task automatic test_backpressure();
    ent_t saved[DEPTH];
    data_wr_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      saved[i] = rand_ent(3'b100, 32'h0000_2000 + 32'(i) * 32'h10);
      drive(1'b1, saved[i]);
      tick();
    end
    drive(1'b0, '0);
    #1;
    checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL full_wr_rdy: got %b want 0", wr_rdy); end
    drive(1'b1, rand_ent(3'b100, 32'h0000_BAD0));
    tick();
    drive(1'b0, '0);
    data_wr_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (dut_head !== {1'b1, saved[i]}) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, dut_head, {1'b1, saved[i]}); end
      tick();
    end
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL extra_dropped: got empty=%b want 1", empty); end
  endtask

  task automatic test_push_pop();
    ent_t a, b;
    a = rand_ent(3'b001, 32'h0000_3000);
    b = rand_ent(3'b111, 32'h0000_3100);
    data_wr_rdy = 1'b0;
    drive(1'b1, a);
    tick();
    drive(1'b1, b);
    data_wr_rdy = 1'b1;
    #1;
    checks++; if (dut_head !== {1'b1, a} || wr_rdy !== 1'b1) begin errors++; $display("FAIL pp_before: got %h rdy=%b want %h rdy=1", dut_head, wr_rdy, {1'b1, a}); end
    tick();
    drive(1'b0, '0);
    data_wr_rdy = 1'b0;
    #1;
    checks++; if (dut_head !== {1'b1, b}) begin errors++; $display("FAIL pp_new_head: got %h want %h", dut_head, {1'b1, b}); end
    // Count stays at one: room remains, and a single pop empties it.
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL pp_count_rdy: got %b want 1", wr_rdy); end
    data_wr_rdy = 1'b1;
    tick();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_count_one: got empty=%b want 1", empty); end
  endtask

  task automatic test_hazard();
    data_wr_rdy = 1'b0;
    drive(1'b1, rand_ent(3'b010, 32'h0000_1234));
    tick();
    drive(1'b0, '0);
    rd_chk_addr = 32'h0000_123C;
    #1;
    checks++; if (rd_chk_hit !== 1'b1) begin errors++; $display("FAIL hz_same_line: got %b want 1", rd_chk_hit); end
    rd_chk_addr = 32'h0000_1244;
    #1;
    checks++; if (rd_chk_hit !== 1'b0) begin errors++; $display("FAIL hz_next_line: got %b want 0", rd_chk_hit); end
    rd_chk_addr = 32'h0000_123C;
    data_wr_rdy = 1'b1;
    #1;
    checks++; if (rd_chk_hit !== 1'b1) begin errors++; $display("FAIL hz_during_pop: got %b want 1", rd_chk_hit); end
    tick();
    #1;
    checks++; if (rd_chk_hit !== 1'b0) begin errors++; $display("FAIL hz_after_pop: got %b want 0", rd_chk_hit); end
    data_wr_rdy = 1'b0;
    drive(1'b1, rand_ent(3'b010, 32'h0000_5550));
    rd_chk_addr = 32'h0000_5558;
    #1;
    checks++; if (rd_chk_hit !== 1'b0) begin errors++; $display("FAIL hz_push_excluded: got %b want 0", rd_chk_hit); end
    tick();
    drive(1'b0, '0);
    #1;
    checks++; if (rd_chk_hit !== 1'b1) begin errors++; $display("FAIL hz_after_push: got %b want 1", rd_chk_hit); end
    data_wr_rdy = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int n, pushed, popped, cyc;
    ent_t seq[$];
    ent_t e;
    n = 3 * DEPTH + 1;
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < n || mq.size() != 0) && cyc < 1000) begin
      e = rand_ent(3'($urandom), $urandom);
      drive((pushed < n) && ($urandom_range(0, 1) == 1), e);
      data_wr_rdy = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (dut_head !== exp_head()) begin errors++; $display("FAIL wrap_head cyc%0d: got %h want %h", cyc, dut_head, exp_head()); end
      if (mq.size() != 0 && data_wr_rdy) begin
        checks++; if (dut_head[166:0] !== seq[popped]) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", popped, dut_head[166:0], seq[popped]); end
        popped++;
      end
      if (wr_req && mq.size() < DEPTH) begin
        seq.push_back(e);
        pushed++;
      end
      tick();
      cyc++;
    end
    drive(1'b0, '0);
    checks++; if (popped != n) begin errors++; $display("FAIL wrap_drained: got %0d want %0d (cycles %0d)", popped, n, cyc); end
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int c = 0; c < 400; c++) begin
      base = 32'h0000_1000 + 32'($urandom_range(0, 3)) * 32'h10;
      drive($urandom_range(0, 1) == 1, rand_ent(3'($urandom), base + 32'($urandom_range(0, 15))));
      data_wr_rdy = ($urandom_range(0, 1) == 1);
      rd_chk_addr = 32'h0000_1000 + 32'($urandom_range(0, 4)) * 32'h10 + 32'($urandom_range(0, 15));
      #1;
      checks++; if (dut_head !== exp_head()) begin errors++; $display("FAIL rnd_head c%0d: got %h want %h", c, dut_head, exp_head()); end
      checks++; if (wr_rdy !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_wr_rdy c%0d: got %b want %b", c, wr_rdy, mq.size() < DEPTH); end
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty c%0d: got %b want %b", c, empty, mq.size() == 0); end
      checks++; if (rd_chk_hit !== exp_hit(rd_chk_addr)) begin errors++; $display("FAIL rnd_hit c%0d: got %b want %b", c, rd_chk_hit, exp_hit(rd_chk_addr)); end
      tick();
    end
    drive(1'b0, '0);
    data_wr_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
  endtask

  task automatic test_reset_mid();
    ent_t first;
    data_wr_rdy = 1'b0;
    first = rand_ent(3'b100, 32'h0000_7000);
    drive(1'b1, first);
    tick();
    drive(1'b1, rand_ent(3'b100, 32'h0000_7010));
    tick();
    drive(1'b1, rand_ent(3'b100, 32'h0000_7020));
    rd_chk_addr = 32'h0000_7004;
    #1;
    checks++; if (dut_head !== {1'b1, first} || rd_chk_hit !== 1'b1) begin errors++; $display("FAIL rm_before: got %h hit=%b want %h hit=1", dut_head, rd_chk_hit, {1'b1, first}); end
    reset = 1'b1;
    #1;
    mq.delete();
    checks++; if (data_wr_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rm_immediate: got req=%b empty=%b want 0/1", data_wr_req, empty); end
    checks++; if (dut_head !== 168'h0 || wr_rdy !== 1'b0 || rd_chk_hit !== 1'b0) begin errors++; $display("FAIL rm_outputs: got head=%h rdy=%b hit=%b want 0/0/0", dut_head, wr_rdy, rd_chk_hit); end
    @(posedge clk); #1;
    drive(1'b0, '0);
    reset = 1'b0;
    #1;
    checks++; if (wr_rdy !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL rm_release: got rdy=%b empty=%b want 1/1", wr_rdy, empty); end
    data_wr_rdy = 1'b1;
    tick();
    #1;
    checks++; if (data_wr_req !== 1'b0 || rd_chk_hit !== 1'b0) begin errors++; $display("FAIL rm_no_stale: got req=%b hit=%b want 0/0", data_wr_req, rd_chk_hit); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_push_pop();
    test_hazard();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_wr_buffer.md
DCACHE_WR_BUFFER -- requirements
Module: dcache_wr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered write entries; legal values 2 and 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports wr_req  input  1, wr_type  input  3, wr_addr  input  32, wr_wstrb  input  4, wr_data  input  128: write request from dcache.
REQ-005 SHALL have port wr_rdy  output  1  buffer can accept a write this cycle.
REQ-006 SHALL have ports data_wr_req  output  1, data_wr_type  output  3, data_wr_addr  output  32, data_wr_wstrb  output  4, data_wr_data  output  128: write request to the cache-to-AXI bridge.
REQ-007 SHALL have port data_wr_rdy  input  1  bridge accepts the presented write.
REQ-008 SHALL have port rd_chk_addr  input  32  address of a pending dcache read miss.
REQ-009 SHALL have port rd_chk_hit  output  1  pending read conflicts with a buffered write.
REQ-010 SHALL have port empty  output  1  no buffered writes.

Function
REQ-011 SHALL store entries {type, addr, wstrb, data} in a FIFO of DEPTH slots with read pointer, write pointer and count (0..DEPTH).
REQ-012 SHALL push one entry when wr_req && wr_rdy, capturing all wr_* fields verbatim, including non-standard wr_type values.
REQ-013 SHALL drive wr_rdy = (count < DEPTH) && !reset; no accept-while-full even if a pop occurs in the same cycle.
REQ-014 SHALL drive data_wr_req = (count != 0), registered-state based, never combinationally from wr_req.
REQ-015 SHALL drive data_wr_type/addr/wstrb/data from the head slot when count != 0, and all-zero when count == 0.
REQ-016 SHALL pop the head entry when data_wr_req && data_wr_rdy; head fields SHALL stay stable while data_wr_req=1 and data_wr_rdy=0.
REQ-017 SHALL have fixed latency: an entry accepted into an empty buffer at edge N appears on data_wr_req in the cycle after edge N; no bypass.
REQ-018 SHALL, on simultaneous push and pop, advance both pointers and leave count unchanged.
REQ-019 SHALL wrap pointers modulo DEPTH.
REQ-020 SHALL preserve strict FIFO order; no merging or reordering of entries.
REQ-021 SHALL drive rd_chk_hit = OR over occupied slots of (slot.addr[31:4] == rd_chk_addr[31:4]), combinationally.
REQ-022 SHALL include the head slot in rd_chk_hit even during the cycle it is popped.
REQ-023 SHALL exclude from rd_chk_hit any entry being pushed in the same cycle.
REQ-024 SHALL drive empty = (count == 0).
REQ-025 SHALL ignore wr_req when wr_rdy=0; count SHALL never exceed DEPTH or underflow.

Reset
REQ-026 SHALL, while reset=1, clear count and both pointers immediately (asynchronously).
REQ-027 SHALL hold outputs during reset at: data_wr_req=0, payload=0, wr_rdy=0, rd_chk_hit=0, empty=1.
REQ-028 SHALL discard all buffered entries on reset mid-operation, including any entry mid-handshake.
REQ-029 SHALL raise wr_rdy=1 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL verify single word write: push type=3'b010, addr=0x1FC0_0010, wstrb=4'b0011, data[31:0]=0xDEAD_BEEF with data_wr_rdy=1 -> data_wr_req=1 next cycle with identical fields; popped; empty=1 one cycle later.
REQ-031 SHALL verify fill and backpressure: hold data_wr_rdy=0 and push DEPTH line writes (type=3'b100) -> wr_rdy=0 after the DEPTH-th push; an extra wr_req is dropped; releasing data_wr_rdy drains entries in push order.
REQ-032 SHALL verify simultaneous push/pop: with count=1, push and pop in the same cycle -> count stays 1; new entry presented next.
REQ-033 SHALL verify the hazard check: buffered addr=0x0000_1234; rd_chk_addr=0x0000_123C -> rd_chk_hit=1; rd_chk_addr=0x0000_1244 -> rd_chk_hit=0; after the entry pops -> rd_chk_hit=0.
REQ-034 SHALL verify pointer wrap-around: 3*DEPTH+1 pushes interleaved with pops -> all entries exit in order with correct data.
REQ-035 SHALL verify reset mid-operation: assert reset with count=2 and data_wr_rdy=0 -> data_wr_req=0 and empty=1 immediately; no stale entry after deassertion.
